// File: rtl/lc3b_types.sv
// Shared types for the LC-3b fetch path: machine word, fixed fetch step for the
// 16-bit word, and the prefetch FSM state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    localparam int FETCH_STEP = $bits(lc3b_word) / 8;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } prefetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched entries {ir, pc, hit, predict}.
// clear empties the queue and rewinds both pointers; clear dominates push/pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             push_ir,
    input  logic [WIDTH-1:0]             push_pc,
    input  logic                         push_hit,
    input  logic                         push_predict,
    output logic [WIDTH-1:0]             head_ir,
    output logic [WIDTH-1:0]             head_pc,
    output logic                         head_hit,
    output logic                         head_predict,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] ir_mem [DEPTH];
    logic [WIDTH-1:0] pc_mem [DEPTH];
    logic [DEPTH-1:0] hit_mem;
    logic [DEPTH-1:0] predict_mem;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Pointer and occupancy bookkeeping; push and pop together keep count.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Entry storage; data is not reset, occupancy alone marks it meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr]      <= push_ir;
            pc_mem[wr_ptr]      <= push_pc;
            hit_mem[wr_ptr]     <= push_hit;
            predict_mem[wr_ptr] <= push_predict;
        end
    end

    assign head_ir      = ir_mem[rd_ptr];
    assign head_pc      = pc_mem[rd_ptr];
    assign head_hit     = hit_mem[rd_ptr];
    assign head_predict = predict_mem[rd_ptr];

endmodule

// File: rtl/prefetch_unit.sv
// Prefetching fetch stage: one outstanding imem read at a time, results queued
// in fetch_queue for decode. A redirect flushes the queue; a read still in
// flight at that point is waited out in DROP and its data thrown away.
// Optional feature macro: PREFETCH_BTB_EN (use BTB prediction for next PC and
// store hit/predict bits per entry; when undefined the btb_* inputs are ignored).
module prefetch_unit
    import lc3b_types::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             imem_rdata,
    input  logic                         imem_resp,
    output logic                         imem_read,
    output logic [WIDTH-1:0]             imem_address,
    input  logic                         redirect,
    input  logic [WIDTH-1:0]             redirect_pc,
    input  logic                         btb_hit,
    input  logic                         btb_predict,
    input  logic [WIDTH-1:0]             btb_target,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [WIDTH-1:0]             ir_out,
    output logic [WIDTH-1:0]             pc_out,
    output logic                         instr_hit_out,
    output logic                         instr_predict_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int               CW   = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(WIDTH / 8);
    localparam logic [CW-1:0]    FULL = CW'(DEPTH);

    prefetch_state_t  state;
    prefetch_state_t  state_next;
    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] req_addr;
    logic             pending;

    logic             read_req;
    logic             resp_take;
    logic             start;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] next_pc;
    logic             push_hit;
    logic             push_predict;

`ifdef PREFETCH_BTB_EN
    assign next_pc      = (btb_hit && btb_predict) ? btb_target : fetch_pc + STEP;
    assign push_hit     = btb_hit;
    assign push_predict = btb_predict;
`else
    logic unused_btb;
    assign unused_btb   = ^{btb_hit, btb_predict, btb_target};
    assign next_pc      = fetch_pc + STEP;
    assign push_hit     = 1'b0;
    assign push_predict = 1'b0;
`endif

    // Request/response decode and next-state; a read issued in the redirect
    // cycle is already at memory, so it is treated like a pending one.
    always_comb begin
        state_next = state;
        read_req   = 1'b0;
        case (state)
            FETCH:   read_req = pending | (count < FULL);
            DROP:    read_req = 1'b1;
            default: read_req = 1'b0;
        endcase
        if (!rst_n) read_req = 1'b0;
        resp_take = read_req & imem_resp;
        start     = read_req & ~pending;
        if (redirect) begin
            if (resp_take)
                state_next = FETCH;
            else if (pending || start)
                state_next = DROP;
        end else if (state == DROP && resp_take) begin
            state_next = FETCH;
        end
    end

    assign push = (state == FETCH) & resp_take & ~redirect;
    assign pop  = deq_valid & deq_ready & ~redirect;

    // FSM, fetch PC and outstanding-read flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            pending  <= 1'b0;
        end else begin
            state <= state_next;
            if (redirect)
                fetch_pc <= redirect_pc;
            else if (push)
                fetch_pc <= next_pc;
            if (resp_take)
                pending <= 1'b0;
            else if (start)
                pending <= 1'b1;
        end
    end

    // Latch the request address so it stays stable while the read is open.
    always_ff @(posedge clk) begin
        if (start) req_addr <= fetch_pc;
    end

    assign imem_read    = read_req;
    assign imem_address = pending ? req_addr : fetch_pc;
    assign deq_valid    = rst_n & (count != '0);

    fetch_queue #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (redirect),
        .push         (push),
        .pop          (pop),
        .push_ir      (imem_rdata),
        .push_pc      (imem_address),
        .push_hit     (push_hit),
        .push_predict (push_predict),
        .head_ir      (ir_out),
        .head_pc      (pc_out),
        .head_hit     (instr_hit_out),
        .head_predict (instr_predict_out),
        .count        (count)
    );

endmodule
